// File: rtl/des_pkg.sv
// Shared DES key-schedule tables and helpers: PC-1/PC-2 index tables, the
// per-round shift schedule, the permutations and the 28-bit half rotations.
package des_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    // Table entries are FIPS bit numbers (1 = leftmost bit).
    localparam logic [5:0] PC1_TAB [0:55] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,  6'd1,
        6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18, 6'd10, 6'd2,
        6'd59, 6'd51, 6'd43, 6'd35, 6'd27, 6'd19, 6'd11, 6'd3,
        6'd60, 6'd52, 6'd44, 6'd36, 6'd63, 6'd55, 6'd47, 6'd39,
        6'd31, 6'd23, 6'd15, 6'd7,  6'd62, 6'd54, 6'd46, 6'd38,
        6'd30, 6'd22, 6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37,
        6'd29, 6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    localparam logic [5:0] PC2_TAB [0:47] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,  6'd3,  6'd28,
        6'd15, 6'd6,  6'd21, 6'd10, 6'd23, 6'd19, 6'd12, 6'd4,
        6'd26, 6'd8,  6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55, 6'd30, 6'd40,
        6'd51, 6'd45, 6'd33, 6'd48, 6'd44, 6'd49, 6'd39, 6'd56,
        6'd34, 6'd53, 6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    localparam logic [1:0] SHIFT_TAB [0:15] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // FIPS bit n of the key sits at vector bit 64-n, i.e. index ~(n-1).
    function automatic logic [55:0] des_pc1(input logic [63:0] key);
        logic [55:0] res;
        res = 56'd0;
        for (int i = 0; i < 56; i++) begin
            res[55 - i] = key[~(PC1_TAB[i] - 6'd1)];
        end
        return res;
    endfunction

    function automatic logic [47:0] des_pc2(input logic [55:0] cd);
        logic [47:0] res;
        res = 48'd0;
        for (int i = 0; i < 48; i++) begin
            res[47 - i] = cd[6'd56 - PC2_TAB[i]];
        end
        return res;
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] res;
        case (n)
            2'd2:    res = {x[25:0], x[27:26]};
            default: res = {x[26:0], x[27]};
        endcase
        return res;
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] n);
        logic [27:0] res;
        case (n)
            2'd2:    res = {x[1:0], x[27:2]};
            default: res = {x[0], x[27:1]};
        endcase
        return res;
    endfunction

    function automatic logic [55:0] cd_rotl(input logic [55:0] cd, input logic [1:0] n);
        return {rotl28(cd[55:28], n), rotl28(cd[27:0], n)};
    endfunction

    function automatic logic [55:0] cd_rotr(input logic [55:0] cd, input logic [1:0] n);
        return {rotr28(cd[55:28], n), rotr28(cd[27:0], n)};
    endfunction

    // Decrypt starts from C0/D0 because the 16 shifts sum to a full 28-bit turn.
    function automatic logic [55:0] des_cd_init(input logic [63:0] key, input logic dec);
        logic [55:0] res;
        if (dec) begin
            res = des_pc1(key);
        end else begin
            res = cd_rotl(des_pc1(key), SHIFT_TAB[0]);
        end
        return res;
    endfunction

    function automatic logic [1:0] des_key_index(input int knum, input logic [1:0] pos,
                                                 input logic dec);
        logic [1:0] idx;
        if (knum == 1) begin
            idx = 2'd0;
        end else if (dec) begin
            idx = 2'd2 - pos;
        end else begin
            idx = pos;
        end
        return idx;
    endfunction

    // EDE: the middle key runs in the opposite direction to the outer two.
    function automatic logic des_key_dir(input int knum, input logic [1:0] pos, input logic dec);
        logic dir;
        if (knum == 1) begin
            dir = dec;
        end else begin
            dir = dec ^ pos[0];
        end
        return dir;
    endfunction

endpackage

// File: rtl/des_key_sched_iter_if.sv
// Key-bundle input channel and subkey output channel of the iterative key scheduler.
interface des_key_sched_iter_if #(
    parameter int KEY_NUM = 1
) ();
    localparam int KW = 64 * KEY_NUM;

    logic          key_valid;
    logic          key_ready;
    logic [KW-1:0] key_in;
    logic          decrypt;
    logic          abort;
    logic          sk_valid;
    logic          sk_ready;
    logic [47:0]   sk_data;
    logic [3:0]    sk_round;
    logic [1:0]    sk_key;
    logic          sk_last;

    modport master (
        output key_valid, key_in, decrypt, abort, sk_ready,
        input  key_ready, sk_valid, sk_data, sk_round, sk_key, sk_last
    );

    modport slave (
        input  key_valid, key_in, decrypt, abort, sk_ready,
        output key_ready, sk_valid, sk_data, sk_round, sk_key, sk_last
    );
endinterface

// File: rtl/des_key_sched_iter_cd_step.sv
// Next C/D value for one subkey step: left rotation ahead of the next round when
// encrypting, right rotation undoing the round just emitted when decrypting.
module des_cd_step
    import des_pkg::*;
(
    input  logic [55:0] i_cd,
    input  logic        i_dec,
    input  logic [3:0]  i_round,
    output logic [55:0] o_cd
);

    logic [3:0] w_idx;
    logic [1:0] w_amt;

    // Pick the schedule entry and rotate both halves.
    always_comb begin
        w_idx = 4'd0;
        o_cd  = i_cd;
        if (i_dec) begin
            w_idx = 4'd15 - i_round;
        end else begin
            w_idx = i_round + 4'd1;
        end
        w_amt = SHIFT_TAB[w_idx];
        if (i_dec) begin
            o_cd = cd_rotr(i_cd, w_amt);
        end else begin
            o_cd = cd_rotl(i_cd, w_amt);
        end
    end

endmodule

// File: rtl/des_key_sched_iter.sv
// Iterative DES/TDES round-key generator: holds 56 bits of C/D state and streams
// one 48-bit subkey per accepted handshake, in the order the round engine needs.
module des_key_sched_iter
    import des_pkg::*;
#(
    parameter int KEY_NUM = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    des_key_sched_iter_if.slave bus
);

    localparam int         KW       = 64 * KEY_NUM;
    localparam logic [1:0] LAST_POS = 2'(KEY_NUM - 1);

    sched_state_e  r_state;
    sched_state_e  w_state_nxt;
    logic [55:0]   r_cd;
    logic [55:0]   w_cd_nxt;
    logic [3:0]    r_round;
    logic [3:0]    w_round_nxt;
    logic [1:0]    r_pos;
    logic [1:0]    w_pos_nxt;
    logic          r_dec;
    logic          w_dec_nxt;
    logic [KW-1:0] r_keys;

    logic          w_key_hs;
    logic          w_cur_dir;
    logic [55:0]   w_cd_step;
    logic [1:0]    w_load_pos;
    logic          w_load_dec;
    logic [KW-1:0] w_load_src;
    logic [63:0]   w_load_key;
    logic          w_load_dir;
    logic [55:0]   w_cd_load;

    assign w_key_hs  = (r_state == ST_IDLE) && bus.key_valid && !bus.abort;
    assign w_cur_dir = des_key_dir(KEY_NUM, r_pos, r_dec);

    des_cd_step u_step (
        .i_cd    (r_cd),
        .i_dec   (w_cur_dir),
        .i_round (r_round),
        .o_cd    (w_cd_step)
    );

    // Key and direction a C/D load would use: the incoming bundle in IDLE,
    // the next key of the latched bundle while running.
    always_comb begin
        w_load_pos = 2'd0;
        w_load_dec = bus.decrypt;
        w_load_src = bus.key_in;
        if (r_state == ST_RUN) begin
            w_load_pos = r_pos + 2'd1;
            w_load_dec = r_dec;
            w_load_src = r_keys;
        end else begin
            w_load_pos = 2'd0;
            w_load_dec = bus.decrypt;
            w_load_src = bus.key_in;
        end
        w_load_key = 64'd0;
        for (int k = 0; k < KEY_NUM; k++) begin
            w_load_key = w_load_key |
                ((des_key_index(KEY_NUM, w_load_pos, w_load_dec) == 2'(k)) ?
                 w_load_src[64*k +: 64] : 64'd0);
        end
        w_load_dir = des_key_dir(KEY_NUM, w_load_pos, w_load_dec);
    end

    assign w_cd_load = des_cd_init(w_load_key, w_load_dir);

    // Next-state logic; leaving RUN clears all schedule state so outputs read as zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cd_nxt    = r_cd;
        w_round_nxt = r_round;
        w_pos_nxt   = r_pos;
        w_dec_nxt   = r_dec;
        case (r_state)
            ST_IDLE: begin
                if (w_key_hs) begin
                    w_state_nxt = ST_RUN;
                    w_cd_nxt    = w_cd_load;
                    w_round_nxt = 4'd0;
                    w_pos_nxt   = 2'd0;
                    w_dec_nxt   = bus.decrypt;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (bus.abort) begin
                    w_state_nxt = ST_IDLE;
                    w_cd_nxt    = 56'd0;
                    w_round_nxt = 4'd0;
                    w_pos_nxt   = 2'd0;
                    w_dec_nxt   = 1'b0;
                end else if (bus.sk_ready) begin
                    if (r_round != 4'd15) begin
                        w_cd_nxt    = w_cd_step;
                        w_round_nxt = r_round + 4'd1;
                    end else if (r_pos != LAST_POS) begin
                        w_cd_nxt    = w_cd_load;
                        w_round_nxt = 4'd0;
                        w_pos_nxt   = r_pos + 2'd1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_cd_nxt    = 56'd0;
                        w_round_nxt = 4'd0;
                        w_pos_nxt   = 2'd0;
                        w_dec_nxt   = 1'b0;
                    end
                end else begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cd_nxt    = 56'd0;
                w_round_nxt = 4'd0;
                w_pos_nxt   = 2'd0;
                w_dec_nxt   = 1'b0;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Schedule registers; the key bundle is captured only on the key handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cd    <= 56'd0;
            r_round <= 4'd0;
            r_pos   <= 2'd0;
            r_dec   <= 1'b0;
            r_keys  <= '0;
        end else begin
            r_cd    <= w_cd_nxt;
            r_round <= w_round_nxt;
            r_pos   <= w_pos_nxt;
            r_dec   <= w_dec_nxt;
            if (w_key_hs) begin
                r_keys <= bus.key_in;
            end
        end
    end

    assign bus.key_ready = (r_state == ST_IDLE);
    assign bus.sk_valid  = (r_state == ST_RUN);
    assign bus.sk_data   = des_pc2(r_cd);
    assign bus.sk_round  = r_round;
    assign bus.sk_key    = des_key_index(KEY_NUM, r_pos, r_dec);
    assign bus.sk_last   = (r_state == ST_RUN) && (r_round == 4'd15) && (r_pos == LAST_POS);

endmodule

// File: doc/des_key_sched_iter.md
Name: des_key_sched_iter

Overview:
- Iterative, parametrised DES round-key generator.
- Accepts one key bundle (single DES or 3-key TDES) with a direction flag, then streams the 48-bit subkeys one per cycle in the order the round datapath consumes them.
- Uses a valid/ready handshake on both sides, so the round engine can stall it.
- Replaces the fully unrolled, combinational 16-subkey table with 56 flops of C/D state plus a shift schedule.

Parameters:
- KEY_NUM, 1, number of 64-bit DES keys per bundle; legal values are 1 (DES) or 3 (TDES EDE).
- KW, 64*KEY_NUM, derived bundle width; not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- key_valid  in  1  key bundle offered
- key_ready  out  1  block idle and able to accept a bundle
- key_in  in  KW  key bundle. Key k (k=0 is K1) occupies key_in[64k+63:64k]. Within each key, FIPS bit n maps to bit [64-n]; parity bits are ignored.
- decrypt  in  1  direction, sampled at key handshake; 0 = encrypt, 1 = decrypt
- abort  in  1  cancel the current schedule
- sk_valid  out  1  subkey available
- sk_ready  in  1  consumer accepts subkey
- sk_data  out  48  subkey, FIPS PC-2 bit 1 on [47]
- sk_round  out  4  position within the current key, 0..15 in emission order
- sk_key  out  2  index of the DES key in use, 0..KEY_NUM-1
- sk_last  out  1  high with the final subkey of the bundle

Behaviour:
- Reset: clk and rst_n only; synchronous, active-low.
- Reset values: key_ready=1, sk_valid=0, sk_data=0, sk_round=0, sk_key=0, sk_last=0.
- States: IDLE and RUN.
- IDLE:
  - key_ready=1, sk_valid=0.
  - On key_valid (key handshake), latch key_in and decrypt, and go to RUN.
  - C/D is loaded from PC-1 of the first key used.
    - Encrypt: C/D is loaded pre-rotated left by s1.
    - Decrypt: C/D is loaded unrotated, since C16=C0.
- RUN:
  - key_ready=0, sk_valid=1.
  - sk_data = PC-2(C,D), taken combinationally from the C/D registers.
  - Latency: the first subkey is valid the cycle after the key handshake.
- Shift schedule: s = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1 for rounds 1..16.
- On each subkey handshake (sk_valid & sk_ready) that is not the last subkey of a key:
  - Encrypt-direction key: C/D rotates left by s of the next round.
  - Decrypt-direction key: C/D rotates right by s of the round just emitted (s16 first).
  - Result, encrypt: K1..K16. Decrypt: K16..K1.
- Per-key direction:
  - KEY_NUM=1: the key uses decrypt.
  - KEY_NUM=3, decrypt=0: keys K1(enc), K2(dec), K3(enc).
  - KEY_NUM=3, decrypt=1: keys K3(dec), K2(enc), K1(dec).
  - sk_key reports the actual key index, not the position in the sequence.
- Key change: the handshake at sk_round=15 of a non-final key loads C/D from PC-1 of the next key, with the correct initial rotation, in the same cycle. There is no bubble.
- Totals: exactly 16*KEY_NUM subkey handshakes per bundle.
- Final subkey:
  - sk_last=1 only on the final subkey.
  - Its handshake returns the block to IDLE; key_ready=1 the next cycle.
  - A new key is never accepted in the same cycle as the final subkey.
- Stall: with sk_ready=0, sk_data, sk_round, sk_key and sk_last hold stable and sk_valid stays high.
- Abort:
  - In RUN: the next state is IDLE, sk_valid drops the next cycle and all outputs return to reset values. Abort has priority over a coincident subkey handshake; that subkey counts as not consumed.
  - In IDLE: abort has priority over key_valid, so no key is accepted.
- rst_n=0 mid-schedule: identical effect to abort, and all state is cleared.
- key_in and decrypt are ignored outside the key handshake.

Decomposition:
- Package des_pkg contains:
  - the PC-1 and PC-2 index tables as localparam arrays;
  - the shift schedule;
  - the function des_pc1(64)->56;
  - the function des_pc2(56)->48;
  - the functions rotl28/rotr28 by 1 or 2.
- One sub-module, des_cd_step: a combinational next C/D given C/D, direction and round.
- Control state and counters live in the top module.

Test Plan:
- KEY_NUM=1, enc, key 0x133457799BBCDFF1, sk_ready=1:
  - 16 consecutive subkeys starting the cycle after the handshake.
  - sk_data round 0 = 0x1B02EFFC7072, round 1 = 0x79AED9DBC9E5, round 15 = 0xCB3D8B0E17F5.
  - sk_last only on the 16th subkey; key_ready=1 the cycle after it.
- Same key, decrypt=1: first subkey 0xCB3D8B0E17F5, last subkey 0x1B02EFFC7072. The full sequence is the reverse of the encrypt sequence.
- Random sk_ready backpressure (about 40% low): outputs are stable while stalled, and the subkey sequence is identical to the unstalled run.
- KEY_NUM=3, K1=K3=0x133457799BBCDFF1, K2=0x0E329232EA6D0D73, enc:
  - 48 handshakes with sk_key sequence 0,1,2.
  - The key-1 block equals the reverse of the single-DES encrypt schedule of K2.
  - No bubble at rounds 15->16 or 31->32.
- KEY_NUM=3, decrypt=1: sk_key sequence 2,1,0; key 2 in decrypt order; sk_last on the 48th subkey only.
- Abort at subkey 7 with sk_ready=1: sk_valid=0 the next cycle, key_ready=1. A new key then restarts at sk_round=0 with the correct K1. Repeat the same case with rst_n=0 instead of abort, and again with abort and key_valid both asserted in IDLE (no key accepted).
